// File: rtl/div64_pkg.sv
// Shared types and constants for the 64-bit divider sequencing controller.
package div64_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } div64_state_t;

  // Bytes per command (dividend + divisor) and per result (quotient + remainder)
  localparam int DIV64_NBYTES = 16;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DIV0    = 2'd1;
  localparam logic [1:0] ERR_DIVERR  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/div64_wdog.sv
// Watchdog counter: cleared while idle, counts while enabled, flags when it
// has reached TIMEOUT.
module div64_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [15:0] r_cnt;

  // Count cycles while enabled; clear has priority; hold at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_expired = (r_cnt == 16'(TIMEOUT));

endmodule

// File: rtl/div64_ctrl.sv
// Byte-serial command/result sequencer around the 64-bit divider: loads the
// operands, screens divide-by-zero, launches one division, watches it with a
// watchdog and streams the 16 result bytes back out.
module div64_ctrl
  import div64_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        sel,
  output logic        div_start,
  output logic [63:0] div_a,
  output logic [63:0] div_b,
  output logic        div_sel,
  input  logic        div_done,
  input  logic [63:0] div_quot,
  input  logic [63:0] div_rem,
  input  logic        div_err,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [3:0] LAST_IDX = 4'(DIV64_NBYTES - 1);

  div64_state_t r_state;
  div64_state_t w_state_next;

  logic [3:0]   r_cnt;
  logic [127:0] r_op;
  logic [127:0] r_res;
  logic         r_sel;
  logic [1:0]   r_err_code;

  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_abort;
  logic [1:0]   w_code;
  logic         w_start;
  logic         w_capture;
  logic         w_expired;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_ready && (r_state == ST_SEND);

  div64_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state != ST_WAIT),
    .i_enable  (r_state == ST_WAIT),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and abort/launch decode; a done seen together with watchdog expiry wins
  always_comb begin
    w_state_next = r_state;
    w_abort      = 1'b0;
    w_code       = ERR_NONE;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (w_in_fire && (r_cnt == LAST_IDX)) begin
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_op[63:0] == 64'd0) begin
          w_abort      = 1'b1;
          w_code       = ERR_DIV0;
          w_state_next = ST_LOAD;
        end else begin
          w_start      = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (div_done) begin
          if (div_err) begin
            w_abort      = 1'b1;
            w_code       = ERR_DIVERR;
            w_state_next = ST_LOAD;
          end else begin
            w_capture    = 1'b1;
            w_state_next = ST_SEND;
          end
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_code       = ERR_TIMEOUT;
          w_state_next = ST_LOAD;
        end
      end
      ST_SEND: begin
        if (w_out_fire && (r_cnt == LAST_IDX)) begin
          w_state_next = ST_LOAD;
        end
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
  end

  // Byte counter shared by the load and send phases; wraps to 0 after byte 15
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_in_fire || w_out_fire) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Operand shift register (first byte ends up as MSB) and sign select capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_sel <= 1'b0;
    end else if (w_in_fire) begin
      r_op <= {r_op[119:0], in_data};
      if (r_cnt == 4'd0) begin
        r_sel <= sel;
      end
    end
  end

  // Result register: loaded on divider completion, shifted out MSB byte first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res <= '0;
    end else if (w_capture) begin
      r_res <= {div_quot, div_rem};
    end else if (w_out_fire) begin
      r_res <= {r_res[119:0], 8'h00};
    end
  end

  // Sticky cause of the most recent abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_code <= ERR_NONE;
    end else if (w_abort) begin
      r_err_code <= w_code;
    end
  end

  assign in_ready  = (r_state == ST_LOAD) && !rst;
  assign div_start = w_start;
  assign div_a     = r_op[127:64];
  assign div_b     = r_op[63:0];
  assign div_sel   = r_sel;
  assign out_valid = (r_state == ST_SEND);
  assign out_data  = r_res[127:120];
  assign out_last  = (r_state == ST_SEND) && (r_cnt == LAST_IDX);
  assign err       = w_abort;
  // The new cause is visible alongside the err pulse, then held
  assign err_code  = w_abort ? w_code : r_err_code;
  assign busy      = !((r_state == ST_LOAD) && (r_cnt == 4'd0));

endmodule
